// File: rtl/wb_gpio.sv
// Wishbone-classic GPIO slave: GPOCNT byte-maskable output bits and one
// synchronized input bit, with a single-cycle registered acknowledge.
module wb_gpio #(
    parameter int GPOCNT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    output logic              ack_o,
    input  logic [3:0]        be_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    input  logic              gpi_i,
    output logic [GPOCNT-1:0] gpo_o
);

    logic              gpi_s1_r;
    logic              gpi_s2_r;
    logic              req_s;
    logic [31:0]       be_mask_s;
    logic [GPOCNT-1:0] gpo_next_s;
    logic              unused_s;

    // Widen the four byte enables into a per-bit write mask.
    function automatic logic [31:0] expand_be(input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'd0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return mask;
    endfunction

    // Request decode and byte-masked next value for the output bank.
    always_comb begin
        req_s      = cyc_i & stb_i & ~ack_o;
        be_mask_s  = expand_be(be_i);
        gpo_next_s = gpo_o;
        if (req_s && we_i) begin
            gpo_next_s = (gpo_o & ~be_mask_s[GPOCNT-1:0])
                       | (dat_i[GPOCNT-1:0] & be_mask_s[GPOCNT-1:0]);
        end else begin
            gpo_next_s = gpo_o;
        end
    end

    // Data bits above GPOCNT have no destination.
    assign unused_s = ^{dat_i, be_mask_s};

    // Synchronizer, acknowledge, read data and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpi_s1_r <= 1'b0;
            gpi_s2_r <= 1'b0;
            ack_o    <= 1'b0;
            dat_o    <= 32'd0;
            gpo_o    <= '0;
        end else begin
            gpi_s1_r <= gpi_i;
            gpi_s2_r <= gpi_s1_r;
            ack_o    <= req_s;
            gpo_o    <= gpo_next_s;
            // Writes load dat_o too; the master ignores it on a write ack.
            if (req_s) begin
                dat_o <= {31'd0, gpi_s2_r};
            end else begin
                dat_o <= dat_o;
            end
        end
    end

endmodule

// File: tb/tb_wb_gpio.sv
// Directed bench for wb_gpio: two instances (GPOCNT=1 and 16) share one bus.
module tb_wb_gpio;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  be;
    logic [31:0] dat_w;
    logic        gpi;
    logic        ack1;
    logic        ack16;
    logic [31:0] dat1;
    logic [31:0] dat16;
    logic [0:0]  gpo1;
    logic [15:0] gpo16;

    int checks_cnt;
    int errors_cnt;

    wb_gpio #(.GPOCNT(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .ack_o(ack1), .be_i(be), .dat_i(dat_w), .dat_o(dat1),
        .gpi_i(gpi), .gpo_o(gpo1)
    );

    wb_gpio #(.GPOCNT(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .ack_o(ack16), .be_i(be), .dat_i(dat_w), .dat_o(dat16),
        .gpi_i(gpi), .gpo_o(gpo16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request: present at edge T, observe ack cycle T+1, then idle.
    task automatic bus_req(input logic w, input logic [3:0] b,
                           input logic [31:0] d);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        be    = b;
        dat_w = d;
        tick();
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst   = 1'b1;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        be    = 4'd0;
        dat_w = 32'd0;
        gpi   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_ack", {31'd0, ack16}, 32'd0);
        check_eq("rst_dat", dat16, 32'd0);
        check_eq("rst_gpo1", {31'd0, gpo1}, 32'd0);
        check_eq("rst_gpo16", {16'd0, gpo16}, 32'd0);

        // Single-bit write 1 then 0.
        bus_req(1'b1, 4'b0001, 32'h0000_0001);
        check_eq("wr1_ack", {31'd0, ack1}, 32'd1);
        check_eq("wr1_gpo1", {31'd0, gpo1}, 32'd1);
        check_eq("wr1_gpo16", {16'd0, gpo16}, 32'h0001);
        tick();
        check_eq("wr1_ack_drop", {31'd0, ack1}, 32'd0);
        check_eq("wr1_gpo1_hold", {31'd0, gpo1}, 32'd1);
        bus_req(1'b1, 4'b0001, 32'h0000_0000);
        check_eq("wr0_gpo1", {31'd0, gpo1}, 32'd0);
        check_eq("wr0_gpo16", {16'd0, gpo16}, 32'h0000);
        tick();

        // Byte enables.
        bus_req(1'b1, 4'b0010, 32'h0000_ABCD);
        check_eq("be2_gpo16", {16'd0, gpo16}, 32'hAB00);
        check_eq("be2_gpo1", {31'd0, gpo1}, 32'd0);
        tick();
        bus_req(1'b1, 4'b0000, 32'h0000_1234);
        check_eq("be0_ack", {31'd0, ack16}, 32'd1);
        check_eq("be0_gpo16", {16'd0, gpo16}, 32'hAB00);
        tick();
        bus_req(1'b1, 4'b1111, 32'hFFFF_1235);
        check_eq("befull_gpo16", {16'd0, gpo16}, 32'h1235);
        check_eq("befull_gpo1", {31'd0, gpo1}, 32'd1);
        tick();

        // Idle strobes do nothing.
        cyc = 1'b1; stb = 1'b0; we = 1'b1; be = 4'b1111; dat_w = 32'd0;
        tick();
        check_eq("cyc_only_ack", {31'd0, ack16}, 32'd0);
        cyc = 1'b0; stb = 1'b1;
        tick();
        check_eq("stb_only_ack", {31'd0, ack16}, 32'd0);
        check_eq("idle_gpo16", {16'd0, gpo16}, 32'h1235);
        stb = 1'b0; we = 1'b0;
        tick();

        // Reads through the synchronizer; a read in the same cycle gpi rises sees 0.
        gpi = 1'b1;
        bus_req(1'b0, 4'b0000, 32'd0);
        check_eq("rd_sync_lat", dat16, 32'd0);
        tick();
        tick();
        tick();
        bus_req(1'b0, 4'b0000, 32'd0);
        check_eq("rd_hi_ack", {31'd0, ack16}, 32'd1);
        check_eq("rd_hi_dat", dat16, 32'h0000_0001);
        tick();
        bus_req(1'b1, 4'b0000, 32'd0);
        check_eq("wr_loads_dat", dat1, 32'h0000_0001);
        tick();
        gpi = 1'b0;
        tick();
        tick();
        tick();
        bus_req(1'b0, 4'b0000, 32'd0);
        check_eq("rd_lo_dat", dat16, 32'd0);
        tick();

        // Held strobe acks every second cycle: 0,1,0,1,0,1.
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("held_ack%0d", i), {31'd0, ack16},
                     (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i < 5) tick();
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
        check_eq("held_end", {31'd0, ack16}, 32'd0);

        // Reset wins over a write request in the same cycle.
        rst = 1'b1;
        bus_req(1'b1, 4'b1111, 32'h0000_FFFF);
        check_eq("rstreq_ack", {31'd0, ack16}, 32'd0);
        check_eq("rstreq_gpo16", {16'd0, gpo16}, 32'd0);
        check_eq("rstreq_gpo1", {31'd0, gpo1}, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("rstreq_after", {31'd0, ack16}, 32'd0);
        check_eq("rstreq_gpo_after", {16'd0, gpo16}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
